// File: rtl/alu_ctrl_if.sv
// Handshake, load, debug-read and ALU-side signal bundle for alu_ctrl.
// slave = the controller, master = upstream source / external ALU.
interface alu_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CODE  = 2
);
  logic [7:0]       instr;
  logic             instr_valid;
  logic             instr_ready;
  logic             ld_valid;
  logic [1:0]       ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [CODE-1:0]  alu_op;
  logic [WIDTH-1:0] alu_y;
  logic             alu_z;
  logic [1:0]       rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             done;
  logic             flag;

  modport slave (
    input  instr, instr_valid, ld_valid, ld_addr, ld_data, alu_y, alu_z, rd_addr,
    output instr_ready, alu_a, alu_b, alu_op, rd_data, done, flag
  );

  modport master (
    output instr, instr_valid, ld_valid, ld_addr, ld_data, alu_y, alu_z, rd_addr,
    input  instr_ready, alu_a, alu_b, alu_op, rd_data, done, flag
  );
endinterface

// File: rtl/alu_ctrl.sv
// Multi-cycle sequencer feeding an external ALU from a 4-entry register file.
// Optional: define ALU_CTRL_R0_ZERO_EN to hardwire r0 to zero.
module alu_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CODE  = 2
) (
  input logic       clk,
  input logic       rst,
  alu_ctrl_if.slave bus
);
  localparam int unsigned REGS = 4;
  localparam int unsigned AW   = 2;
`ifdef ALU_CTRL_R0_ZERO_EN
  localparam logic R0_ZERO = 1'b1;
`else
  localparam logic R0_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EXEC, S_WB} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rf_q [REGS];
  logic [WIDTH-1:0] rf_view [REGS];
  logic [7:0]       ir_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [CODE-1:0]  alu_op_q;
  logic             flag_q;
  logic             done_q;
  logic             instr_ready_c;
  logic [AW-1:0]    ir_dst;
  logic [AW-1:0]    ir_srca;
  logic [AW-1:0]    ir_srcb;

  assign ir_dst  = ir_q[5:4];
  assign ir_srca = ir_q[3:2];
  assign ir_srcb = ir_q[1:0];

  function automatic logic wr_allowed(input logic [AW-1:0] addr);
    return !(R0_ZERO && (addr == '0));
  endfunction

  // Architectural view of the register file (r0 masked when hardwired).
  always_comb begin
    for (int unsigned i = 0; i < REGS; i++) rf_view[i] = rf_q[i];
    if (R0_ZERO) rf_view[0] = '0;
  end

  // Word ops take the ALU word; compare ops take the zero-extended flag.
  assign res_d = alu_op_q[1] ? WIDTH'(bus.alu_z) : bus.alu_y;

  assign instr_ready_c = (state_q == S_IDLE) && !bus.ld_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      for (int unsigned i = 0; i < REGS; i++) rf_q[i] <= '0;
      ir_q     <= '0;
      res_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      flag_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.ld_valid) begin
            if (wr_allowed(bus.ld_addr)) rf_q[bus.ld_addr] <= bus.ld_data;
          end else if (bus.instr_valid) begin
            ir_q    <= bus.instr;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          alu_a_q  <= rf_view[ir_srca];
          alu_b_q  <= rf_view[ir_srcb];
          alu_op_q <= CODE'(ir_q[7:6]);
          state_q  <= S_EXEC;
        end
        S_EXEC: begin
          res_q   <= res_d;
          done_q  <= 1'b1;
          state_q <= S_WB;
        end
        S_WB: begin
          if (wr_allowed(ir_dst)) rf_q[ir_dst] <= res_q;
          flag_q  <= res_q[0];
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.instr_ready = instr_ready_c;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.rd_data     = rf_view[bus.rd_addr];
  assign bus.done        = done_q;
  assign bus.flag        = flag_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: vector table, corner sequences, random run.
module tb_alu_ctrl;
  localparam int unsigned W = 4;
`ifdef ALU_CTRL_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_ctrl_if #(.WIDTH(W), .CODE(2)) bus ();
  alu_ctrl #(.WIDTH(W), .CODE(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [W-1:0] rf_m [4];
  logic         flag_m;

  typedef struct {
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    logic [7:0]   instr;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic [W-1:0] eres;
  } vec_t;
  vec_t vecs [8];

  // External ALU stand-in: word result for add/sub, AND (ignored) for compare ops.
  function automatic logic [W-1:0] alu_y_f(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic alu_z_f(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    return (op == 2'd2) ? (a > b) : (a == b);
  endfunction

  always_comb begin
    bus.alu_y = alu_y_f(bus.alu_op, bus.alu_a, bus.alu_b);
    bus.alu_z = alu_z_f(bus.alu_op, bus.alu_a, bus.alu_b);
  end

  // Reference result from the instruction semantics, modulo 2^W.
  function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned ia = a;
    int unsigned ib = b;
    case (op)
      2'd0:    return W'((ia + ib) % 16);
      2'd1:    return W'((ia + 16 - ib) % 16);
      2'd2:    return (ia > ib) ? W'(1) : W'(0);
      default: return (ia == ib) ? W'(1) : W'(0);
    endcase
  endfunction

  function automatic logic [W-1:0] rd_m(input logic [1:0] a);
    return (R0Z && a == 2'd0) ? W'(0) : rf_m[a];
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic check_rd(input string nm, input logic [1:0] a, input logic [W-1:0] exp);
    bus.rd_addr = a;
    #1;
    check(nm, 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic do_load(input logic [1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
    bus.ld_data  = d;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    if (!(R0Z && a == 2'd0)) rf_m[a] = d;
    check_rd($sformatf("load_r%0d", a), a, rd_m(a));
  endtask

  // One instruction end to end, with ignored loads thrown in during the busy cycles.
  task automatic run_instr(input string nm, input logic [7:0] ins,
                           input logic [W-1:0] ea, input logic [W-1:0] eb, input logic [W-1:0] eres);
    logic [1:0] dst;
    dst = ins[5:4];
    @(negedge clk);
    #1;
    check({nm, "_ready_idle"}, 32'(bus.instr_ready), 32'd1);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = 8'($urandom);
    check({nm, "_ready_issue"}, 32'(bus.instr_ready), 32'd0);
    check({nm, "_done_issue"}, 32'(bus.done), 32'd0);
    bus.ld_valid = 1'b1; bus.ld_addr = 2'($urandom); bus.ld_data = W'($urandom);
    @(negedge clk);
    check({nm, "_alu_a"}, 32'(bus.alu_a), 32'(ea));
    check({nm, "_alu_b"}, 32'(bus.alu_b), 32'(eb));
    check({nm, "_alu_op"}, 32'(bus.alu_op), 32'(ins[7:6]));
    check({nm, "_done_exec"}, 32'(bus.done), 32'd0);
    bus.ld_addr = 2'($urandom); bus.ld_data = W'($urandom);
    @(negedge clk);
    check({nm, "_done_wb"}, 32'(bus.done), 32'd1);
    check({nm, "_ready_wb"}, 32'(bus.instr_ready), 32'd0);
    bus.ld_addr = 2'($urandom); bus.ld_data = W'($urandom);
    @(negedge clk);
    bus.ld_valid = 1'b0;
    if (!(R0Z && dst == 2'd0)) rf_m[dst] = eres;
    flag_m = eres[0];
    check_rd({nm, "_result"}, dst, rd_m(dst));
    check({nm, "_done_after"}, 32'(bus.done), 32'd0);
    check({nm, "_flag"}, 32'(bus.flag), 32'(flag_m));
    check({nm, "_ready_after"}, 32'(bus.instr_ready), 32'd1);
  endtask

  initial begin
    int acc;
    int dn;
    int last;
    logic [7:0] ins;
    logic [W-1:0] a;
    logic [W-1:0] b;

    vecs[0] = '{r1: 4'd7,  r2: 4'd12, instr: 8'h36, ea: 4'd7,  eb: 4'd12, eres: 4'd3};
    vecs[1] = '{r1: 4'd5,  r2: 4'd2,  instr: 8'hB6, ea: 4'd5,  eb: 4'd2,  eres: 4'd1};
    vecs[2] = '{r1: 4'd3,  r2: 4'd9,  instr: 8'h76, ea: 4'd3,  eb: 4'd9,  eres: 4'd10};
    vecs[3] = '{r1: 4'd6,  r2: 4'd6,  instr: 8'hE6, ea: 4'd6,  eb: 4'd6,  eres: 4'd1};
    vecs[4] = '{r1: 4'd4,  r2: 4'd9,  instr: 8'h96, ea: 4'd4,  eb: 4'd9,  eres: 4'd0};
    vecs[5] = '{r1: 4'd4,  r2: 4'd0,  instr: 8'h15, ea: 4'd4,  eb: 4'd4,  eres: 4'd8};
    vecs[6] = '{r1: 4'd15, r2: 4'd1,  instr: 8'h36, ea: 4'd15, eb: 4'd1,  eres: 4'd0};
    vecs[7] = '{r1: 4'd2,  r2: 4'd8,  instr: 8'h59, ea: 4'd8,  eb: 4'd2,  eres: 4'd6};

    rst = 1'b1;
    bus.instr = '0; bus.instr_valid = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.rd_addr = '0;
    for (int i = 0; i < 4; i++) rf_m[i] = '0;
    flag_m = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    #1;
    check("rst_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_flag", 32'(bus.flag), 32'd0);
    check("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check("rst_alu_b", 32'(bus.alu_b), 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    for (int i = 0; i < 4; i++) check_rd($sformatf("rst_r%0d", i), 2'(i), W'(0));

    // Vector table
    for (int i = 0; i < 8; i++) begin
      do_load(2'd1, vecs[i].r1);
      do_load(2'd2, vecs[i].r2);
      run_instr($sformatf("vec%0d", i), vecs[i].instr, vecs[i].ea, vecs[i].eb, vecs[i].eres);
    end

    // Compare result written into r0
    do_load(2'd1, 4'd5);
    do_load(2'd2, 4'd2);
    run_instr("gt_r0", 8'h86, 4'd5, 4'd2, 4'd1);

    // Load and instruction together: load wins, instruction taken next cycle
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.ld_addr = 2'd3; bus.ld_data = 4'd9;
    bus.instr = 8'h1F; bus.instr_valid = 1'b1;
    #1;
    check("prio_ready_low", 32'(bus.instr_ready), 32'd0);
    @(negedge clk);
    bus.ld_valid = 1'b0;
    rf_m[3] = 4'd9;
    check_rd("prio_load_written", 2'd3, 4'd9);
    check("prio_ready_high", 32'(bus.instr_ready), 32'd1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("prio_accepted", 32'(bus.instr_ready), 32'd0);
    @(negedge clk);
    check("prio_alu_a", 32'(bus.alu_a), 32'd9);
    check("prio_alu_b", 32'(bus.alu_b), 32'd9);
    @(negedge clk);
    check("prio_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    rf_m[1] = 4'd2; flag_m = 1'b0;
    check_rd("prio_r1", 2'd1, 4'd2);

    // Held instr_valid: one acceptance every 4 cycles
    @(negedge clk);
    bus.instr = 8'hF5; bus.instr_valid = 1'b1;
    acc = 0; dn = 0; last = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.instr_ready) begin
        if (last >= 0) check($sformatf("thru_gap%0d", i), 32'(i - last), 32'd4);
        last = i;
        acc++;
      end
      if (bus.done) dn++;
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    check("thru_accepts", 32'(acc), 32'd5);
    check("thru_dones", 32'(dn), 32'd5);
    rf_m[3] = 4'd1; flag_m = 1'b1;
    check_rd("thru_r3", 2'd3, 4'd1);
    check("thru_flag", 32'(bus.flag), 32'd1);

    // Reset during EXEC aborts the write-back
    do_load(2'd1, 4'd3);
    do_load(2'd2, 4'd6);
    @(negedge clk);
    bus.instr = 8'h26; bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    check("mid_in_exec_a", 32'(bus.alu_a), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) rf_m[i] = '0;
    flag_m = 1'b0;
    check("mid_done0", 32'(bus.done), 32'd0);
    check("mid_flag", 32'(bus.flag), 32'd0);
    check("mid_alu_a", 32'(bus.alu_a), 32'd0);
    check_rd("mid_r2", 2'd2, 4'd0);
    check("mid_ready", 32'(bus.instr_ready), 32'd1);
    @(negedge clk);
    check("mid_done1", 32'(bus.done), 32'd0);
    check_rd("mid_r2_late", 2'd2, 4'd0);

    // Random instructions against the reference model
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(1, 0) == 1) do_load(2'($urandom), W'($urandom));
      ins = 8'($urandom);
      a = rd_m(ins[3:2]);
      b = rd_m(ins[1:0]);
      run_instr($sformatf("rnd%0d", k), ins, a, b, ref_res(ins[7:6], a, b));
    end
    for (int i = 0; i < 4; i++) check_rd($sformatf("final_r%0d", i), 2'(i), rd_m(2'(i)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Sequencing controller that sits directly upstream of the `alu` combinational datapath: it accepts 8-bit instructions over a valid/ready handshake, reads two operands from an internal 4-entry register file, and drives them with the opcode onto the ALU inputs. It then captures the ALU result and writes it back to the register file. One instruction is in flight at a time (multi-cycle, non-pipelined). A side load port initialises registers.

## Interface
- `WIDTH`, 4 — data width; must match the ALU's `WIDTH`.
- `CODE`, 2 — opcode width; must match the ALU's `CODE`. Fixed at 2 by the instruction format.
- `clk` input 1 — single clock; all state updates on rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `instr` input 8 — instruction `{op[7:6], dst[5:4], srca[3:2], srcb[1:0]}`.
- `instr_valid` input 1 — `instr` is valid.
- `instr_ready` output 1 — controller can accept an instruction this cycle.
- `ld_valid` input 1 — register load request.
- `ld_addr` input 2 — load target register.
- `ld_data` input WIDTH — load value.
- `alu_a` output WIDTH — operand A to the ALU.
- `alu_b` output WIDTH — operand B to the ALU.
- `alu_op` output CODE — opcode to the ALU.
- `alu_y` input WIDTH — ALU word result.
- `alu_z` input 1 — ALU flag result.
- `rd_addr` input 2 — debug read address.
- `rd_data` output WIDTH — combinational read of `rf[rd_addr]`.
- `done` output 1 — one-cycle pulse when write-back occurs.
- `flag` output 1 — bit 0 of the most recently written-back value.

## Operation
- The FSM has four states: IDLE, ISSUE, EXEC, WB.
- **IDLE:** `instr_ready`=1 unless `ld_valid`=1.
  - `ld_valid` writes `rf[ld_addr]`<=`ld_data` and suppresses `instr_ready` that cycle. Load has priority over instruction acceptance.
  - On `instr_valid && instr_ready`, latch `instr` into `ir` and go to ISSUE.
- **ISSUE:** register `alu_a`<=`rf[srca]`, `alu_b`<=`rf[srcb]`, `alu_op`<=`op`, then go to EXEC.
- **EXEC:** ALU outputs settle from the registered operands. At the end of the cycle, capture the result:
  - op 00 or 01: `res`<=`alu_y`.
  - op 10 or 11: `res`<=`{WIDTH-1 zeros, alu_z}`.
  - Go to WB.
- **WB:** `rf[dst]`<=`res`, `flag`<=`res[0]`, `done`=1 for this cycle only, then return to IDLE.
- `ld_valid` outside IDLE is ignored (no write, no queueing).
- Source/destination overlap (e.g. dst==srca) is legal. Operands are read in ISSUE, before WB, so the old value is used.
- Arithmetic wraps modulo 2^WIDTH; the controller never widens results.

## Timing
- Reset values: state=IDLE, every `rf` entry=0, `ir`=0, `res`=0, `alu_a`=0, `alu_b`=0, `alu_op`=0, `flag`=0, `done`=0.
- `instr_ready`=1 in the first cycle after reset deasserts, provided `ld_valid`=0.
- Latency from the accept edge T:
  - T+1: ISSUE.
  - T+2: `alu_a`/`alu_b`/`alu_op` valid, EXEC.
  - T+3: WB, `done`=1.
  - T+4: the register holds the result and `instr_ready`=1 again.
- Throughput is one instruction per 4 cycles.
- `instr_ready` is 0 in ISSUE, EXEC and WB. An upstream source holding `instr_valid` high is not accepted until IDLE.
- `rd_data` is combinational. It shows the new value from the cycle after the write edge.
- `rst` asserted in any state aborts the instruction in flight (no write-back, no `done`) and returns all state to reset values on that edge.

## Configuration
- `ALU_CTRL_R0_ZERO_EN` defined:
  - `rf[0]` is hardwired to 0; writes to it from WB or the load port are discarded.
  - `rd_data` and operand reads of r0 return 0.
  - `flag` and `done` still update on a WB to r0.
- Undefined: r0 is an ordinary register.

## Test plan
- Reset then idle: after `rst`, `rd_data`=0 for all 4 addresses, `instr_ready`=1, `done`=0, `alu_a`=`alu_b`=0.
- Load and ADD (WIDTH=4): load r1=7, r2=12; issue `00_11_01_10`.
  - At T+2, `alu_a`=7, `alu_b`=12, `alu_op`=00.
  - With the bench ALU model driving `alu_y`=3, at T+3 `done`=1 and afterwards r3=3, `flag`=1.
- GT flag write-back: r1=5, r2=2; issue op 10 into r0, with the bench driving `alu_z`=1.
  - Without the macro: r0=1.
  - With `ALU_CTRL_R0_ZERO_EN`: r0 reads 0, `flag`=1, `done` pulses.
- Handshake/priority:
  - `ld_valid` and `instr_valid` asserted together in IDLE: the load is written and `instr_ready`=0; the instruction is accepted the next cycle.
  - `instr_valid` held high through the busy cycles: exactly one instruction is accepted per 4 cycles.
- Overlap: r1=4; issue op 00 with dst=srca=srcb=r1 and the bench driving `alu_y`=8 → operands are 4/4, r1=8 after WB.
- Reset mid-operation: assert `rst` in EXEC → no `done`, destination register is 0 (reset), state=IDLE on the next cycle.
